// File: rtl/vend_pkg.sv
// Shared constants for the vending-machine coin sequencer: state encoding,
// default pricing and the coin-count width used by the inventory counter.
package vend_pkg;

    localparam int COIN_W             = 8;
    localparam int DEFAULT_PRICE      = 4;
    localparam int DEFAULT_MAX_CREDIT = 15;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACCEPT   = 3'd1;
    localparam logic [2:0] S_VEND     = 3'd2;
    localparam logic [2:0] S_PAY      = 3'd3;
    localparam logic [2:0] S_PAY_WAIT = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == S_VEND) || (st == S_PAY) || (st == S_PAY_WAIT);
    endfunction

endpackage

// File: rtl/vend_controller.sv
// Coin sequencer: tracks credit, strobes the coin-inventory counter,
// dispenses items and pays change one coin per two cycles.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = DEFAULT_PRICE,
    parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              coin_in,
    input  logic              vend_req,
    input  logic              cancel,
    input  logic [COIN_W-1:0] coins,
    output logic              enable,
    output logic              inc_sig,
    output logic              dec_sig,
    output logic              dispense,
    output logic              change_out,
    output logic              coin_reject,
    output logic [COIN_W-1:0] credit,
    output logic              busy,
    output logic              fault
);

    localparam logic [COIN_W-1:0] PRICE_C = COIN_W'(PRICE);
    localparam logic [COIN_W-1:0] MAX_C   = COIN_W'(MAX_CREDIT);
    localparam logic [COIN_W-1:0] ONE_C   = COIN_W'(1);

    logic [2:0]        state, state_n;
    logic [COIN_W-1:0] credit_n;
    logic              inc_n, dec_n, dispense_n, change_n, reject_n;

    // Request priority in IDLE/ACCEPT is cancel > coin_in > vend_req; a
    // coin that loses arbitration is handed back rather than silently eaten.
    always_comb begin
        state_n    = state;
        credit_n   = credit;
        inc_n      = 1'b0;
        dec_n      = 1'b0;
        dispense_n = 1'b0;
        change_n   = 1'b0;
        reject_n   = 1'b0;
        case (state)
            S_IDLE, S_ACCEPT: begin
                if (cancel) begin
                    reject_n = coin_in;
                    if (credit != '0) state_n = S_PAY;
                end else if (coin_in) begin
                    if (credit < MAX_C) begin
                        credit_n = credit + ONE_C;
                        inc_n    = 1'b1;
                        state_n  = S_ACCEPT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end else if (vend_req && (credit >= PRICE_C)) begin
                    credit_n   = credit - PRICE_C;
                    dispense_n = 1'b1;
                    state_n    = S_VEND;
                end
            end
            S_VEND: begin
                reject_n = coin_in;
                state_n  = (credit != '0) ? S_PAY : S_IDLE;
            end
            S_PAY: begin
                reject_n = coin_in;
                if (coins != '0) begin
                    credit_n = credit - ONE_C;
                    dec_n    = 1'b1;
                    change_n = 1'b1;
                    state_n  = S_PAY_WAIT;
                end else begin
                    state_n = S_FAULT;
                end
            end
            S_PAY_WAIT: begin
                reject_n = coin_in;
                state_n  = (credit != '0) ? S_PAY : S_IDLE;
            end
            S_FAULT: begin
                reject_n = coin_in;
            end
            default: begin
                state_n  = S_IDLE;
                credit_n = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so every output is a flop.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= S_IDLE;
            credit      <= '0;
            inc_sig     <= 1'b0;
            dec_sig     <= 1'b0;
            dispense    <= 1'b0;
            change_out  <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            inc_sig     <= inc_n;
            dec_sig     <= dec_n;
            dispense    <= dispense_n;
            change_out  <= change_n;
            coin_reject <= reject_n;
            busy        <= is_busy(state_n);
            fault       <= (state_n == S_FAULT);
        end
    end

    assign enable = inc_sig;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: purchase, change payout, credit cap,
// request arbitration, empty-inventory fault and reset during payout.
module tb_vend_controller;

    logic       CLK = 1'b0;
    logic       reset;
    logic       coin_in, vend_req, cancel;
    logic [7:0] coins;
    logic       enable, inc_sig, dec_sig, dispense, change_out, coin_reject;
    logic [7:0] credit;
    logic       busy, fault;

    int errors = 0;
    int checks = 0;

    // Observed flag vector: {enable, inc_sig, dec_sig, dispense, change_out, coin_reject, busy, fault}
    logic [7:0] obs;
    assign obs = {enable, inc_sig, dec_sig, dispense, change_out, coin_reject, busy, fault};

    localparam logic [7:0] F_NONE   = 8'h00;
    localparam logic [7:0] F_INC    = 8'hC0;
    localparam logic [7:0] F_VEND   = 8'h12;
    localparam logic [7:0] F_BUSY   = 8'h02;
    localparam logic [7:0] F_CHANGE = 8'h2A;
    localparam logic [7:0] F_REJ    = 8'h04;
    localparam logic [7:0] F_REJBSY = 8'h06;
    localparam logic [7:0] F_FAULT  = 8'h01;
    localparam logic [7:0] F_REJFLT = 8'h05;

    vend_controller dut (
        .CLK(CLK), .reset(reset), .coin_in(coin_in), .vend_req(vend_req),
        .cancel(cancel), .coins(coins), .enable(enable), .inc_sig(inc_sig),
        .dec_sig(dec_sig), .dispense(dispense), .change_out(change_out),
        .coin_reject(coin_reject), .credit(credit), .busy(busy), .fault(fault)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; coin_in = 1'b0; vend_req = 1'b0; cancel = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic insert_coins(input int n);
        for (int i = 0; i < n; i++) begin
            coin_in = 1'b1;
            tick();
            if (obs !== F_INC || credit !== 8'(i + 1)) begin
                errors++;
                $display("FAIL coin_insert[%0d]: flags=%h credit=%0d expected flags=%h credit=%0d",
                         i, obs, credit, F_INC, i + 1);
            end
            checks++;
        end
        coin_in = 1'b0;
    endtask

    task automatic test_reset();
        coins = 8'd10;
        do_reset();
        tick();
        checks++;
        if (obs !== F_NONE) begin
            errors++;
            $display("FAIL reset_flags: got %h expected %h", obs, F_NONE);
        end
        checks++;
        if (credit !== 8'd0) begin
            errors++;
            $display("FAIL reset_credit: got %0d expected 0", credit);
        end
    endtask

    task automatic test_vend_exact();
        do_reset();
        insert_coins(4);
        vend_req = 1'b1;
        tick();
        vend_req = 1'b0;
        checks++;
        if (obs !== F_VEND || credit !== 8'd0) begin
            errors++;
            $display("FAIL vend_exact_dispense: flags=%h credit=%0d expected flags=%h credit=0", obs, credit, F_VEND);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== F_NONE || credit !== 8'd0) begin
                errors++;
                $display("FAIL vend_exact_idle[%0d]: flags=%h credit=%0d expected flags=00 credit=0", i, obs, credit);
            end
        end
    endtask

    task automatic test_vend_change();
        logic [7:0] exp_f [6];
        logic [7:0] exp_c [6];
        exp_f = '{F_VEND, F_BUSY, F_CHANGE, F_BUSY, F_CHANGE, F_NONE};
        exp_c = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
        do_reset();
        coins = 8'd10;
        insert_coins(6);
        vend_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vend_req = 1'b0;
            checks++;
            if (obs !== exp_f[i] || credit !== exp_c[i]) begin
                errors++;
                $display("FAIL vend_change[%0d]: flags=%h credit=%0d expected flags=%h credit=%0d",
                         i, obs, credit, exp_f[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_credit_cap();
        do_reset();
        insert_coins(15);
        coin_in = 1'b1;
        tick();
        coin_in = 1'b0;
        checks++;
        if (obs !== F_REJ || credit !== 8'd15) begin
            errors++;
            $display("FAIL credit_cap: flags=%h credit=%0d expected flags=%h credit=15", obs, credit, F_REJ);
        end
    endtask

    task automatic test_priority();
        // cancel in IDLE does nothing
        do_reset();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (obs !== F_NONE || credit !== 8'd0) begin
            errors++;
            $display("FAIL cancel_idle: flags=%h credit=%0d expected flags=00 credit=0", obs, credit);
        end
        // coin beats vend; vend is dropped even though credit covers the price
        insert_coins(4);
        coin_in = 1'b1; vend_req = 1'b1;
        tick();
        coin_in = 1'b0; vend_req = 1'b0;
        checks++;
        if (obs !== F_INC || credit !== 8'd5) begin
            errors++;
            $display("FAIL coin_over_vend: flags=%h credit=%0d expected flags=%h credit=5", obs, credit, F_INC);
        end
        // vend below price is ignored
        do_reset();
        insert_coins(3);
        vend_req = 1'b1;
        tick();
        vend_req = 1'b0;
        checks++;
        if (obs !== F_NONE || credit !== 8'd3) begin
            errors++;
            $display("FAIL vend_short: flags=%h credit=%0d expected flags=00 credit=3", obs, credit);
        end
    endtask

    task automatic test_cancel_with_coin();
        logic [7:0] exp_f [6];
        logic [7:0] exp_c [6];
        exp_f = '{F_CHANGE, F_BUSY, F_CHANGE, F_BUSY, F_CHANGE, F_NONE};
        exp_c = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
        do_reset();
        coins = 8'd20;
        insert_coins(3);
        coin_in = 1'b1; cancel = 1'b1;
        tick();
        coin_in = 1'b0; cancel = 1'b0;
        checks++;
        if (obs !== F_REJBSY || credit !== 8'd3) begin
            errors++;
            $display("FAIL cancel_coin_reject: flags=%h credit=%0d expected flags=%h credit=3", obs, credit, F_REJBSY);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs !== exp_f[i] || credit !== exp_c[i]) begin
                errors++;
                $display("FAIL refund[%0d]: flags=%h credit=%0d expected flags=%h credit=%0d",
                         i, obs, credit, exp_f[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_fault();
        do_reset();
        coins = 8'd1;
        insert_coins(3);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        checks++;
        if (obs !== F_CHANGE || credit !== 8'd2) begin
            errors++;
            $display("FAIL fault_first_change: flags=%h credit=%0d expected flags=%h credit=2", obs, credit, F_CHANGE);
        end
        coins = 8'd0;
        tick();
        tick();
        checks++;
        if (obs !== F_FAULT || credit !== 8'd2) begin
            errors++;
            $display("FAIL fault_entry: flags=%h credit=%0d expected flags=%h credit=2", obs, credit, F_FAULT);
        end
        coin_in = 1'b1;
        tick();
        coin_in = 1'b0;
        checks++;
        if (obs !== F_REJFLT || credit !== 8'd2) begin
            errors++;
            $display("FAIL fault_coin: flags=%h credit=%0d expected flags=%h credit=2", obs, credit, F_REJFLT);
        end
        coins = 8'd9; cancel = 1'b1; vend_req = 1'b1;
        tick();
        cancel = 1'b0; vend_req = 1'b0;
        checks++;
        if (obs !== F_FAULT || credit !== 8'd2) begin
            errors++;
            $display("FAIL fault_sticky: flags=%h credit=%0d expected flags=%h credit=2", obs, credit, F_FAULT);
        end
        do_reset();
        checks++;
        if (obs !== F_NONE || credit !== 8'd0) begin
            errors++;
            $display("FAIL fault_reset: flags=%h credit=%0d expected flags=00 credit=0", obs, credit);
        end
    endtask

    task automatic test_reset_mid_pay();
        do_reset();
        coins = 8'd10;
        insert_coins(6);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        checks++;
        if (obs !== F_CHANGE || credit !== 8'd5) begin
            errors++;
            $display("FAIL midpay_setup: flags=%h credit=%0d expected flags=%h credit=5", obs, credit, F_CHANGE);
        end
        do_reset();
        checks++;
        if (obs !== F_NONE || credit !== 8'd0) begin
            errors++;
            $display("FAIL midpay_reset: flags=%h credit=%0d expected flags=00 credit=0", obs, credit);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== F_NONE || credit !== 8'd0) begin
                errors++;
                $display("FAIL midpay_quiet[%0d]: flags=%h credit=%0d expected flags=00 credit=0", i, obs, credit);
            end
        end
        insert_coins(1);
    endtask

    initial begin
        reset = 1'b1; coin_in = 1'b0; vend_req = 1'b0; cancel = 1'b0; coins = 8'd0;
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_credit_cap();
        test_priority();
        test_cancel_with_coin();
        test_fault();
        test_reset_mid_pay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
